// File: rtl/ov5640_dvp_capture_if.sv
// ---------------------------------------------------------------------------
// ov5640_dvp_capture_if
//   Groups the OV5640 DVP input bus and the captured RGB565 pixel stream.
//   master : the capture block (samples cam_*, drives pix_*).
//   slave  : the sensor/consumer side (drives cam_*, samples pix_*).
// Signals:
//   cam_vsync  DVP VSYNC
//   cam_href   DVP HREF, high during active line bytes
//   cam_data   DVP data byte
//   pix_data   RGB565 pixel, {first byte, second byte}
//   pix_valid  one-cycle qualifier per pixel
//   pix_sof    first pixel of frame (with pix_valid)
//   pix_eol    last pixel of line (with pix_valid)
// ---------------------------------------------------------------------------
interface ov5640_dvp_capture_if;
   logic        cam_vsync;
   logic        cam_href;
   logic [7:0]  cam_data;
   logic [15:0] pix_data;
   logic        pix_valid;
   logic        pix_sof;
   logic        pix_eol;

   modport master (
      input  cam_vsync, cam_href, cam_data,
      output pix_data, pix_valid, pix_sof, pix_eol
   );

   modport slave (
      output cam_vsync, cam_href, cam_data,
      input  pix_data, pix_valid, pix_sof, pix_eol
   );
endinterface

// File: rtl/ov5640_dvp_capture.sv
// ---------------------------------------------------------------------------
// ov5640_dvp_capture
//   Captures the OV5640 8-bit DVP stream in the PCLK domain, pairs bytes into
//   RGB565 pixels, discards the first DROP_FRAMES frames after sensor init and
//   emits a pixel stream with frame/line markers and integrity flags.
// Ports:
//   Clk         camera PCLK
//   Rst_p       asynchronous active-high reset
//   Init_Done   sensor init complete (asynchronous, synchronised here)
//   dvp         DVP input bus and pixel output stream (master modport)
//   frame_done  one-cycle pulse when a captured frame is closed by VSYNC
//   frame_cnt   number of captured frames completed (wraps)
//   line_err    sticky: a line had the wrong byte count
//   frame_err   sticky: a frame had the wrong line count
// ---------------------------------------------------------------------------
module ov5640_dvp_capture #(
   parameter int unsigned IMAGE_WIDTH  = 640,
   parameter int unsigned IMAGE_HEIGHT = 720,
   parameter int unsigned DROP_FRAMES  = 10,
   parameter bit          VSYNC_POL    = 1'b1
) (
   input  logic                         Clk,
   input  logic                         Rst_p,
   input  logic                         Init_Done,
   ov5640_dvp_capture_if.master         dvp,
   output logic                         frame_done,
   output logic [15:0]                  frame_cnt,
   output logic                         line_err,
   output logic                         frame_err
);

   localparam int unsigned ColW  = $clog2(IMAGE_WIDTH + 1);
   localparam int unsigned RowW  = $clog2(IMAGE_HEIGHT + 1);
   localparam int unsigned DropW = (DROP_FRAMES == 0) ? 1 : $clog2(DROP_FRAMES + 1);

   typedef enum logic [1:0] {StIdle, StDrop, StCapture} state_e;

   state_e state_q, state_d;

   logic init_meta_q, init_s_q;
   logic vsync_d1_q, vsync_d2_q;
   logic href_d1_q, href_d2_q;
   logic [7:0] data_d1_q;

   logic [ColW-1:0]  col_q, col_d;
   logic [RowW-1:0]  row_q, row_d;
   logic [DropW-1:0] drop_cnt_q, drop_cnt_d;
   logic             phase_q, phase_d;
   // Set when a complete pixel arrives after the line is already full.
   logic             ovf_q, ovf_d;
   logic [7:0]       hi_q, hi_d;

   logic [15:0] pix_data_q, pix_data_d;
   logic        pix_valid_q, pix_valid_d;
   logic        pix_sof_q, pix_sof_d;
   logic        pix_eol_q, pix_eol_d;
   logic        frame_done_q, frame_done_d;
   logic [15:0] frame_cnt_q, frame_cnt_d;
   logic        line_err_q, line_err_d;
   logic        frame_err_q, frame_err_d;

   logic vs_edge, href_rise, href_fall, cur_phase, col_full, row_full;

   assign vs_edge   = VSYNC_POL ? (vsync_d1_q & ~vsync_d2_q) : (~vsync_d1_q & vsync_d2_q);
   assign href_rise = href_d1_q & ~href_d2_q;
   assign href_fall = ~href_d1_q & href_d2_q;
   // A new line always starts on the high byte, whatever a glitch left behind.
   assign cur_phase = href_rise ? 1'b0 : phase_q;
   assign col_full  = (col_q == ColW'(IMAGE_WIDTH));
   assign row_full  = (row_q == RowW'(IMAGE_HEIGHT));

   always_comb begin
      state_d      = state_q;
      col_d        = col_q;
      row_d        = row_q;
      drop_cnt_d   = drop_cnt_q;
      phase_d      = phase_q;
      ovf_d        = ovf_q;
      hi_d         = hi_q;
      pix_data_d   = pix_data_q;
      pix_valid_d  = 1'b0;
      pix_sof_d    = 1'b0;
      pix_eol_d    = 1'b0;
      frame_done_d = 1'b0;
      frame_cnt_d  = frame_cnt_q;
      line_err_d   = line_err_q;
      frame_err_d  = frame_err_q;

      if (!init_s_q) begin
         // Loss of init abandons any partial frame; flags and frame_cnt survive.
         state_d = StIdle;
      end else begin
         case (state_q)
            StIdle: begin
               drop_cnt_d = '0;
               state_d    = StDrop;
            end

            StDrop: begin
               if (vs_edge) begin
                  if (drop_cnt_q == DropW'(DROP_FRAMES)) begin
                     state_d = StCapture;
                     row_d   = '0;
                     col_d   = '0;
                     phase_d = 1'b0;
                     ovf_d   = 1'b0;
                  end else begin
                     drop_cnt_d = drop_cnt_q + DropW'(1);
                  end
               end
            end

            StCapture: begin
               if (href_fall) begin
                  if (!col_full || phase_q || ovf_q) begin
                     line_err_d = 1'b1;
                  end
                  if (!row_full) begin
                     row_d = row_q + RowW'(1);
                  end
                  col_d   = '0;
                  phase_d = 1'b0;
                  ovf_d   = 1'b0;
               end else if (href_d1_q) begin
                  if (!cur_phase) begin
                     hi_d    = data_d1_q;
                     phase_d = 1'b1;
                  end else begin
                     phase_d = 1'b0;
                     if (row_full) begin
                        // Extra lines beyond the frame are dropped silently.
                        pix_valid_d = 1'b0;
                     end else if (col_full) begin
                        ovf_d = 1'b1;
                     end else begin
                        pix_data_d  = {hi_q, data_d1_q};
                        pix_valid_d = 1'b1;
                        pix_sof_d   = (row_q == '0) && (col_q == '0);
                        pix_eol_d   = (col_q == ColW'(IMAGE_WIDTH - 1));
                        col_d       = col_q + ColW'(1);
                     end
                  end
               end

               // VSYNC overrides the line bookkeeping above (row is not advanced
               // by a coincident HREF fall, but its line check still counts).
               if (vs_edge) begin
                  frame_done_d = 1'b1;
                  frame_cnt_d  = frame_cnt_q + 16'd1;
                  if (!row_full) begin
                     frame_err_d = 1'b1;
                  end
                  row_d       = '0;
                  col_d       = '0;
                  phase_d     = 1'b0;
                  ovf_d       = 1'b0;
                  pix_valid_d = 1'b0;
                  pix_sof_d   = 1'b0;
                  pix_eol_d   = 1'b0;
                  pix_data_d  = pix_data_q;
               end
            end

            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge Clk or posedge Rst_p) begin
      if (Rst_p) begin
         state_q      <= StIdle;
         init_meta_q  <= 1'b0;
         init_s_q     <= 1'b0;
         vsync_d1_q   <= 1'b0;
         vsync_d2_q   <= 1'b0;
         href_d1_q    <= 1'b0;
         href_d2_q    <= 1'b0;
         data_d1_q    <= '0;
         col_q        <= '0;
         row_q        <= '0;
         drop_cnt_q   <= '0;
         phase_q      <= 1'b0;
         ovf_q        <= 1'b0;
         hi_q         <= '0;
         pix_data_q   <= '0;
         pix_valid_q  <= 1'b0;
         pix_sof_q    <= 1'b0;
         pix_eol_q    <= 1'b0;
         frame_done_q <= 1'b0;
         frame_cnt_q  <= '0;
         line_err_q   <= 1'b0;
         frame_err_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         init_meta_q  <= Init_Done;
         init_s_q     <= init_meta_q;
         vsync_d1_q   <= dvp.cam_vsync;
         vsync_d2_q   <= vsync_d1_q;
         href_d1_q    <= dvp.cam_href;
         href_d2_q    <= href_d1_q;
         data_d1_q    <= dvp.cam_data;
         col_q        <= col_d;
         row_q        <= row_d;
         drop_cnt_q   <= drop_cnt_d;
         phase_q      <= phase_d;
         ovf_q        <= ovf_d;
         hi_q         <= hi_d;
         pix_data_q   <= pix_data_d;
         pix_valid_q  <= pix_valid_d;
         pix_sof_q    <= pix_sof_d;
         pix_eol_q    <= pix_eol_d;
         frame_done_q <= frame_done_d;
         frame_cnt_q  <= frame_cnt_d;
         line_err_q   <= line_err_d;
         frame_err_q  <= frame_err_d;
      end
   end

   assign dvp.pix_data  = pix_data_q;
   assign dvp.pix_valid = pix_valid_q;
   assign dvp.pix_sof   = pix_sof_q;
   assign dvp.pix_eol   = pix_eol_q;
   assign frame_done    = frame_done_q;
   assign frame_cnt     = frame_cnt_q;
   assign line_err      = line_err_q;
   assign frame_err     = frame_err_q;

endmodule

// File: tb/tb_ov5640_dvp_capture.sv
// ---------------------------------------------------------------------------
// tb_ov5640_dvp_capture
//   Two instances: A (W=4, H=3, DROP_FRAMES=2, rising VSYNC) driven through a
//   frame table with a frame/line-level reference model, and B (DROP_FRAMES=0,
//   falling VSYNC) for first-edge capture, latency and VSYNC/HREF coincidence.
// ---------------------------------------------------------------------------
module tb_ov5640_dvp_capture;

   localparam int W    = 4;
   localparam int H    = 3;
   localparam int DROP = 2;

   logic Clk = 1'b0;
   logic Rst_p = 1'b1;
   logic init_a = 1'b0;
   logic init_b = 1'b0;

   always #5 Clk = ~Clk;

   ov5640_dvp_capture_if a_if ();
   ov5640_dvp_capture_if b_if ();

   logic        fd_a, le_a, fe_a, fd_b, le_b, fe_b;
   logic [15:0] fc_a, fc_b;

   ov5640_dvp_capture #(
      .IMAGE_WIDTH (W),
      .IMAGE_HEIGHT(H),
      .DROP_FRAMES (DROP),
      .VSYNC_POL   (1'b1)
   ) u_dut_a (
      .Clk       (Clk),
      .Rst_p     (Rst_p),
      .Init_Done (init_a),
      .dvp       (a_if),
      .frame_done(fd_a),
      .frame_cnt (fc_a),
      .line_err  (le_a),
      .frame_err (fe_a)
   );

   ov5640_dvp_capture #(
      .IMAGE_WIDTH (W),
      .IMAGE_HEIGHT(H),
      .DROP_FRAMES (0),
      .VSYNC_POL   (1'b0)
   ) u_dut_b (
      .Clk       (Clk),
      .Rst_p     (Rst_p),
      .Init_Done (init_b),
      .dvp       (b_if),
      .frame_done(fd_b),
      .frame_cnt (fc_b),
      .line_err  (le_b),
      .frame_err (fe_b)
   );

   int vectors = 0;
   int miscompares = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // ---------------- reference model for instance A (frame/line level) -------
   typedef struct packed {
      logic [15:0] data;
      logic        sof;
      logic        eol;
   } pix_t;
   typedef logic [7:0] byte_q_t[$];

   pix_t exp_q[$];
   int   m_mode = 0;  // 0 waiting for init, 1 discarding frames, 2 capturing
   int   m_seen = 0;
   int   m_row  = 0;

   task automatic model_vsync();
      if (m_mode == 1) begin
         if (m_seen == DROP) begin
            m_mode = 2;
            m_row  = 0;
         end else begin
            m_seen++;
         end
      end else if (m_mode == 2) begin
         m_row = 0;
      end
   endtask

   task automatic model_line(input byte_q_t b);
      int n, lim;
      pix_t p;
      if (m_mode != 2) return;
      n = b.size();
      if (m_row < H) begin
         lim = (n / 2 < W) ? n / 2 : W;
         for (int k = 0; k < lim; k++) begin
            p.data = {b[2*k], b[2*k+1]};
            p.sof  = (m_row == 0) && (k == 0);
            p.eol  = (k == W - 1);
            exp_q.push_back(p);
         end
      end
      m_row = (m_row + 1 < H) ? m_row + 1 : H;
   endtask

   // ---------------- monitors -----------------------------------------------
   int cyc = 0;
   always @(posedge Clk) cyc <= cyc + 1;

   int pix_cnt_a = 0;
   int fd_cnt_a  = 0;
   bit mon_en    = 1'b1;

   always @(negedge Clk) begin
      if (!Rst_p) begin
         if (a_if.pix_valid) begin
            pix_cnt_a++;
            if (mon_en) begin
               if (exp_q.size() == 0) begin
                  vectors++;
                  miscompares++;
                  $display("FAIL unexpected_pixel: got data 0x%0h with no pixel expected",
                           a_if.pix_data);
               end else begin
                  pix_t p;
                  p = exp_q.pop_front();
                  chk("pix_data", a_if.pix_data, p.data);
                  chk("pix_sof", a_if.pix_sof, p.sof);
                  chk("pix_eol", a_if.pix_eol, p.eol);
               end
            end
         end
         if (fd_a) fd_cnt_a++;
      end
   end

   int          b_pix_cnt = 0;
   int          b_fd_cnt  = 0;
   int          b_first_cyc = 0;
   logic        b_first_sof = 1'b0;
   logic [15:0] b_first_data = '0;

   always @(negedge Clk) begin
      if (!Rst_p) begin
         if (b_if.pix_valid) begin
            if (b_pix_cnt == 0) begin
               b_first_cyc  = cyc;
               b_first_sof  = b_if.pix_sof;
               b_first_data = b_if.pix_data;
            end
            b_pix_cnt++;
         end
         if (fd_b) b_fd_cnt++;
      end
   end

   // ---------------- drivers for instance A ---------------------------------
   task automatic a_vsync();
      model_vsync();
      repeat (4) begin
         @(negedge Clk);
         a_if.cam_vsync = 1'b1;
      end
      repeat (4) begin
         @(negedge Clk);
         a_if.cam_vsync = 1'b0;
      end
   endtask

   task automatic a_line(input int n, input bit rnd);
      byte_q_t b;
      for (int k = 0; k < n; k++) begin
         if (rnd) b.push_back(8'($urandom_range(0, 255)));
         else     b.push_back((k % 2 == 0) ? 8'hF8 : 8'h1F);
      end
      model_line(b);
      for (int k = 0; k < n; k++) begin
         @(negedge Clk);
         a_if.cam_href = 1'b1;
         a_if.cam_data = b[k];
      end
      @(negedge Clk);
      a_if.cam_href = 1'b0;
      a_if.cam_data = 8'h00;
      repeat (3) @(negedge Clk);
   endtask

   task automatic a_frame(input int nlines, input int nbytes, input bit rnd);
      for (int l = 0; l < nlines; l++) a_line(nbytes, rnd);
   endtask

   // ---------------- frame table --------------------------------------------
   typedef struct {
      int nlines;
      int nbytes;
      bit rnd;
      int exp_pix;
      int exp_fcnt;
      bit exp_lerr;
      bit exp_ferr;
   } vec_t;

   vec_t vecs[5];

   // Instance A stimulus: reset, drop phase, table of frames, init loss.
   initial begin : main_a
      int p0, d0, snap, fc0;
      vecs[0] = '{3, 8,  1'b0, 12, 1, 1'b0, 1'b0};  // 0xF81F pixels
      vecs[1] = '{3, 8,  1'b1, 12, 2, 1'b0, 1'b0};
      vecs[2] = '{3, 10, 1'b1, 12, 3, 1'b1, 1'b0};  // 5 pixels per line
      vecs[3] = '{2, 8,  1'b1, 8,  4, 1'b1, 1'b1};  // short frame
      vecs[4] = '{3, 8,  1'b1, 12, 5, 1'b1, 1'b1};  // flags stay sticky

      a_if.cam_vsync = 1'b0;
      a_if.cam_href  = 1'b0;
      a_if.cam_data  = 8'h00;
      b_if.cam_vsync = 1'b1;
      b_if.cam_href  = 1'b0;
      b_if.cam_data  = 8'h00;

      repeat (3) @(negedge Clk);
      chk("reset_pix_valid", a_if.pix_valid, 0);
      chk("reset_pix_data", a_if.pix_data, 0);
      chk("reset_sof_eol", {a_if.pix_sof, a_if.pix_eol}, 0);
      chk("reset_frame_done", fd_a, 0);
      chk("reset_frame_cnt", fc_a, 0);
      chk("reset_flags", {le_a, fe_a}, 0);
      Rst_p = 1'b0;

      // Drop phase: edge 1 aligns, two frames discarded, edge 3 starts capture.
      @(negedge Clk);
      init_a = 1'b1;
      m_mode = 1;
      m_seen = 0;
      repeat (6) @(negedge Clk);
      a_vsync();
      a_frame(3, 8, 1'b1);
      a_vsync();
      a_frame(3, 8, 1'b1);
      a_vsync();
      chk("drop_no_pixels", pix_cnt_a, 0);
      chk("drop_no_frame_done", fd_cnt_a, 0);

      for (int i = 0; i < 5; i++) begin
         p0 = pix_cnt_a;
         d0 = fd_cnt_a;
         a_frame(vecs[i].nlines, vecs[i].nbytes, vecs[i].rnd);
         a_vsync();
         repeat (2) @(negedge Clk);
         chk($sformatf("v%0d_pixels", i), pix_cnt_a - p0, vecs[i].exp_pix);
         chk($sformatf("v%0d_frame_done", i), fd_cnt_a - d0, 1);
         chk($sformatf("v%0d_frame_cnt", i), fc_a, vecs[i].exp_fcnt);
         chk($sformatf("v%0d_line_err", i), le_a, vecs[i].exp_lerr);
         chk($sformatf("v%0d_frame_err", i), fe_a, vecs[i].exp_ferr);
      end

      // Init loss mid-line: pixels stop within 3 Clk, no frame_done.
      m_mode = 0;
      mon_en = 1'b0;
      d0   = fd_cnt_a;
      fc0  = int'(fc_a);
      snap = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge Clk);
         a_if.cam_href = 1'b1;
         a_if.cam_data = 8'($urandom_range(0, 255));
         if (k == 3) init_a = 1'b0;
         if (k == 5) begin
            #1;
            snap = pix_cnt_a;
         end
      end
      @(negedge Clk);
      a_if.cam_href = 1'b0;
      repeat (3) @(negedge Clk);
      a_vsync();
      repeat (2) @(negedge Clk);
      chk("initloss_pixels_stop", pix_cnt_a, snap);
      chk("initloss_no_frame_done", fd_cnt_a, d0);
      chk("initloss_frame_cnt_kept", fc_a, fc0);
      chk("initloss_flags_kept", {le_a, fe_a}, 2'b11);

      // Re-raise: the full drop count repeats before capture resumes.
      init_a = 1'b1;
      m_mode = 1;
      m_seen = 0;
      mon_en = 1'b1;
      repeat (6) @(negedge Clk);
      a_vsync();
      a_frame(3, 8, 1'b1);
      a_vsync();
      a_frame(3, 8, 1'b1);
      a_vsync();
      chk("redrop_no_pixels", pix_cnt_a, snap);
      p0 = pix_cnt_a;
      a_frame(3, 8, 1'b1);
      a_vsync();
      repeat (2) @(negedge Clk);
      chk("recapture_pixels", pix_cnt_a - p0, 12);
      chk("recapture_frame_cnt", fc_a, fc0 + 1);
      chk("expected_queue_drained", exp_q.size(), 0);

      run_b();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   // Instance B: capture on the very first falling VSYNC edge, 2-Clk latency,
   // and the last HREF fall landing on the closing VSYNC edge.
   task automatic run_b();
      int lo_cyc;
      lo_cyc = 0;
      @(negedge Clk);
      init_b = 1'b1;
      repeat (6) @(negedge Clk);
      b_if.cam_vsync = 1'b0;
      repeat (4) @(negedge Clk);
      b_if.cam_vsync = 1'b1;
      repeat (4) @(negedge Clk);
      for (int l = 0; l < 3; l++) begin
         for (int k = 0; k < 8; k++) begin
            @(negedge Clk);
            b_if.cam_href = 1'b1;
            b_if.cam_data = (k % 2 == 0) ? 8'h12 : 8'h34;
            if (l == 0 && k == 1) lo_cyc = cyc;
         end
         @(negedge Clk);
         b_if.cam_href = 1'b0;
         if (l == 2) b_if.cam_vsync = 1'b0;
         repeat (4) @(negedge Clk);
         b_if.cam_vsync = 1'b1;
      end
      repeat (4) @(negedge Clk);
      chk("b_pixels", b_pix_cnt, 12);
      chk("b_first_sof", b_first_sof, 1'b1);
      chk("b_first_data", b_first_data, 16'h1234);
      chk("b_latency", b_first_cyc - lo_cyc, 2);
      chk("b_frame_done", b_fd_cnt, 1);
      chk("b_frame_cnt", fc_b, 1);
      chk("b_line_err", le_b, 1'b0);
      chk("b_frame_err", fe_b, 1'b1);
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation did not finish, vectors=%0d", vectors);
      $fatal(1, "timeout");
   end

endmodule
